ncc_result_tx: RTL and testbench

Result transmitter for the NCC matcher: the outbound counterpart of the byte-wide descriptor loader on the PCI side. Accepts one match result per handshake (signed correlation score plus window x/y), buffers results in a small FIFO, and serializes each as a fixed 10-byte frame onto an 8-bit host-facing stream with valid/ready backpressure. Sits between the processing-element array's peak picker and the PCI output path.

---
 rtl/ncc_result_tx.sv | 109 ++++++++++
 tb/tb_ncc_result_tx.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ncc_result_tx.sv
// ncc_result_tx: FIFO-buffered NCC results (res* in) serialized as 10-byte checksummed frames on the pciOut byte stream (clk, rst active-low sync)
module ncc_result_tx #(
  parameter int fifoDepth = 4,
  parameter int coordWidth = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  resValid,
  output logic                  resReady,
  input  logic [31:0]           resScore,
  input  logic [coordWidth-1:0] resX,
  input  logic [coordWidth-1:0] resY,
  output logic [7:0]            pciOut,
  output logic                  pciOutValid,
  input  logic                  pciOutReady,
  output logic [15:0]           frameCount,
  output logic                  busy
);
  localparam int aw = $clog2(fifoDepth);
  localparam int ew = 32 + 2 * coordWidth;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [ew-1:0] mem [fifoDepth];
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic [aw:0] count;
  logic full, empty, push, pop, adv, done;
  logic [ew-1:0] head;
  logic [31:0] h_score, f_score;
  logic [15:0] h_x, h_y, f_x, f_y;
  logic [7:0] h_csum, f_csum;
  logic [3:0] idx, idx_nx;
  logic [7:0] fb [10];
  assign full = count == (aw + 1)'(fifoDepth);
  assign empty = count == '0;
  assign resReady = rst && !full;
  assign push = resValid && resReady;
  assign busy = !empty || state == SEND;
  assign head = mem[rd_ptr];
  assign h_score = head[ew-1 -: 32];
  assign h_x = 16'(head[2*coordWidth-1 -: coordWidth]);
  assign h_y = 16'(head[coordWidth-1:0]);
  assign h_csum = h_score[31:24] ^ h_score[23:16] ^ h_score[15:8] ^ h_score[7:0]
                ^ h_x[15:8] ^ h_x[7:0] ^ h_y[15:8] ^ h_y[7:0];
  assign fb[0] = 8'hA5;
  assign fb[1] = f_score[31:24];
  assign fb[2] = f_score[23:16];
  assign fb[3] = f_score[15:8];
  assign fb[4] = f_score[7:0];
  assign fb[5] = f_x[15:8];
  assign fb[6] = f_x[7:0];
  assign fb[7] = f_y[15:8];
  assign fb[8] = f_y[7:0];
  assign fb[9] = f_csum;
  assign idx_nx = idx + 4'd1;
  always_comb begin
    state_nx = state;
    pop = 1'b0;
    adv = 1'b0;
    done = 1'b0;
    if (state == IDLE) begin
      pop = !empty;
      state_nx = empty ? IDLE : SEND;
    end else if (pciOutValid && pciOutReady) begin
      adv = idx != 4'd9;
      done = idx == 4'd9;
      pop = done && !empty;
      state_nx = (done && empty) ? IDLE : SEND;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {resScore, resX, resY};
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      idx <= '0;
      pciOut <= '0;
      pciOutValid <= 1'b0;
      frameCount <= '0;
      f_score <= '0;
      f_x <= '0;
      f_y <= '0;
      f_csum <= '0;
    end else begin
      state <= state_nx;
      wr_ptr <= wr_ptr + aw'(push);
      rd_ptr <= rd_ptr + aw'(pop);
      count <= count + (aw + 1)'(push) - (aw + 1)'(pop);
      frameCount <= frameCount + 16'(done);
      if (pop) begin
        f_score <= h_score;
        f_x <= h_x;
        f_y <= h_y;
        f_csum <= h_csum;
        idx <= '0;
        pciOut <= 8'hA5;
        pciOutValid <= 1'b1;
      end else if (adv) begin
        idx <= idx_nx;
        pciOut <= fb[idx_nx];
      end else if (done) begin
        idx <= '0;
        pciOutValid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ncc_result_tx.sv
// tb_ncc_result_tx: directed checks of framing, latency, backpressure, FIFO full and reset behaviour
module tb_ncc_result_tx;
  logic clk = 1'b0;
  logic rst, resValid, resReady, pciOutValid, pciOutReady, busy;
  logic [31:0] resScore;
  logic [9:0] resX, resY;
  logic [7:0] pciOut;
  logic [15:0] frameCount;
  int checks = 0;
  int failures = 0;
  logic [7:0] f1 [10] = '{8'hA5, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00, 8'h05, 8'h00, 8'h0A, 8'h29};
  logic [7:0] f2 [10] = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h03, 8'hFF, 8'h00, 8'h00, 8'h03};
  logic [7:0] f3 [10] = '{8'hA5, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h55, 8'h02, 8'hAA, 8'hFC};
  logic [7:0] f5 [10] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
  ncc_result_tx #(.fifoDepth(4), .coordWidth(10)) dut (
    .clk(clk), .rst(rst), .resValid(resValid), .resReady(resReady),
    .resScore(resScore), .resX(resX), .resY(resY),
    .pciOut(pciOut), .pciOutValid(pciOutValid), .pciOutReady(pciOutReady),
    .frameCount(frameCount), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] s, input logic [9:0] x, input logic [9:0] y);
    resValid = 1'b1;
    resScore = s;
    resX = x;
    resY = y;
    step();
    resValid = 1'b0;
  endtask
  task automatic recv(input string tag, input logic [7:0] e [10]);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("%s_v%0d", tag, i), 32'(pciOutValid), 32'd1);
      chk($sformatf("%s_b%0d", tag, i), 32'(pciOut), 32'(e[i]));
      step();
    end
  endtask
  initial begin
    logic pv;
    logic [7:0] pd, ex;
    int got, k, j;
    rst = 1'b0;
    resValid = 1'b0;
    resScore = '0;
    resX = '0;
    resY = '0;
    pciOutReady = 1'b1;
    repeat (3) step();
    chk("rst_valid", 32'(pciOutValid), 32'd0);
    chk("rst_data", 32'(pciOut), 32'h00);
    chk("rst_count", 32'(frameCount), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(resReady), 32'd0);
    rst = 1'b1;
    #1;
    chk("rel_ready", 32'(resReady), 32'd1);
    push(32'h0000_1234, 10'd5, 10'd10);
    chk("lat_pre_valid", 32'(pciOutValid), 32'd0);
    chk("lat_busy", 32'(busy), 32'd1);
    step();
    recv("single", f1);
    chk("single_count", 32'(frameCount), 32'd1);
    chk("single_valid_end", 32'(pciOutValid), 32'd0);
    chk("single_busy_end", 32'(busy), 32'd0);
    push(32'hFFFF_FF00, 10'h3FF, 10'd0);
    step();
    recv("neg", f2);
    chk("neg_count", 32'(frameCount), 32'd2);
    push(32'h89AB_CDEF, 10'h155, 10'h2AA);
    got = 0;
    for (int c = 0; c < 300 && got < 10; c++) begin
      pciOutReady = 1'($urandom_range(0, 1));
      pv = pciOutValid;
      pd = pciOut;
      step();
      if (pv && pciOutReady) begin
        chk($sformatf("bp_b%0d", got), 32'(pd), 32'(f3[got]));
        got++;
      end else if (pv) begin
        chk("bp_stall_valid", 32'(pciOutValid), 32'd1);
        chk("bp_stall_data", 32'(pciOut), 32'(pd));
      end
    end
    chk("bp_bytes", 32'(got), 32'd10);
    pciOutReady = 1'b1;
    chk("bp_count", 32'(frameCount), 32'd3);
    chk("bp_valid_end", 32'(pciOutValid), 32'd0);
    pciOutReady = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      chk($sformatf("full_ready%0d", n), 32'(resReady), 32'd1);
      push(32'(n), 10'(n), 10'(n));
    end
    chk("full_ready_low", 32'(resReady), 32'd0);
    resValid = 1'b1;
    resScore = 32'd6;
    resX = 10'd6;
    resY = 10'd6;
    step();
    step();
    chk("full_ready_hold", 32'(resReady), 32'd0);
    chk("full_stall_valid", 32'(pciOutValid), 32'd1);
    chk("full_stall_data", 32'(pciOut), 32'hA5);
    chk("full_busy", 32'(busy), 32'd1);
    resValid = 1'b0;
    pciOutReady = 1'b1;
    for (int i = 0; i < 50; i++) begin
      k = i / 10 + 1;
      j = i % 10;
      ex = (j == 0) ? 8'hA5 : (j == 4 || j == 6 || j == 8 || j == 9) ? 8'(k) : 8'h00;
      chk($sformatf("drain_v%0d", i), 32'(pciOutValid), 32'd1);
      chk($sformatf("drain_b%0d", i), 32'(pciOut), 32'(ex));
      step();
    end
    chk("drain_count", 32'(frameCount), 32'd8);
    chk("drain_valid_end", 32'(pciOutValid), 32'd0);
    chk("drain_busy_end", 32'(busy), 32'd0);
    push(32'h1122_3344, 10'd1, 10'd2);
    step();
    repeat (4) step();
    chk("mid_byte4", 32'(pciOut), 32'h44);
    rst = 1'b0;
    step();
    chk("mid_rst_valid", 32'(pciOutValid), 32'd0);
    chk("mid_rst_count", 32'(frameCount), 32'd0);
    chk("mid_rst_ready", 32'(resReady), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    push(32'h0000_0001, 10'd0, 10'd0);
    step();
    recv("post_rst", f5);
    chk("post_rst_count", 32'(frameCount), 32'd1);
    chk("post_rst_valid_end", 32'(pciOutValid), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
